// File: rtl/tube_scroll_sched_pkg.sv
// Shared constants, FSM encoding and byte-merge helper for tube_scroll_sched.
package tube_scroll_sched_pkg;

    localparam logic [31:0] BASE           = 32'h0000_7f60;
    localparam logic [31:0] TUBE_DATA_ADDR = 32'h0000_7f50;
    localparam logic [31:0] TUBE_LO        = 32'h0000_7f50;
    localparam logic [31:0] TUBE_HI        = 32'h0000_7f57;
    localparam logic [31:0] WIN_BYTES      = 32'd28;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_PERIOD = 3'd1;
    localparam logic [2:0] REG_BUF0   = 3'd2;
    localparam logic [2:0] REG_BUF3   = 3'd5;
    localparam logic [2:0] REG_STATUS = 3'd6;

    localparam int unsigned CTRL_EN     = 0;
    localparam int unsigned CTRL_DIR    = 1;
    localparam int unsigned CTRL_REPEAT = 2;
    localparam int unsigned CTRL_IRQ_EN = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_PEND,
        S_STEP
    } state_e;

    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] r;
        for (int unsigned i = 0; i < 4; i++) begin
            r[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return r;
    endfunction

    function automatic logic in_tube(input logic [31:0] a);
        return (a >= TUBE_LO) && (a <= TUBE_HI);
    endfunction

    function automatic logic in_win(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + WIN_BYTES);
    endfunction

endpackage

// File: rtl/tube_port_arb.sv
// Tube port mux: CPU accesses to the tube range win; otherwise a pending scroller write is granted.
module tube_port_arb
    import tube_scroll_sched_pkg::*;
(
    input  logic [31:0] Addr,
    input  logic [3:0]  ByteEn,
    input  logic [31:0] Din,
    input  logic        pend_i,
    input  logic [31:0] window_i,
    output logic [31:0] tube_Addr,
    output logic [3:0]  tube_ByteEn,
    output logic [31:0] tube_Din,
    output logic        grant_o
);

    always_comb begin
        tube_Addr   = '0;
        tube_ByteEn = '0;
        tube_Din    = '0;
        grant_o     = 1'b0;
        if (in_tube(Addr)) begin
            tube_Addr   = Addr;
            tube_ByteEn = ByteEn;
            tube_Din    = Din;
        end else if (pend_i) begin
            tube_Addr   = TUBE_DATA_ADDR;
            tube_ByteEn = '1;
            tube_Din    = window_i;
            grant_o     = 1'b1;
        end
    end

endmodule

// File: rtl/tube_scroll_sched.sv
// Scrolls a 32-nibble buffer across the 8-digit tube and arbitrates the tube port.
// Optional irq output is enabled by defining TUBE_SCROLL_IRQ_EN.
module tube_scroll_sched
    import tube_scroll_sched_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Addr,
    input  logic [3:0]  ByteEn,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic [31:0] tube_Addr,
    output logic [3:0]  tube_ByteEn,
    output logic [31:0] tube_Din,
    input  logic [31:0] tube_Dout
`ifdef TUBE_SCROLL_IRQ_EN
    ,
    output logic        irq
`endif
);

`ifdef TUBE_SCROLL_IRQ_EN
    localparam logic [3:0] CTRL_MASK = 4'hF;
`else
    localparam logic [3:0] CTRL_MASK = 4'h7;
`endif

    state_e       state_q, state_d;
    logic [3:0]   ctrl_q, ctrl_d;
    logic [31:0]  period_q, period_d;
    logic [127:0] buf_q, buf_d;
    logic [4:0]   pos_q, pos_d;
    logic         done_q, done_d;
    logic [31:0]  cnt_q, cnt_d;

    logic [2:0]   widx;
    logic [1:0]   bsel;
    logic         win_hit, cpu_wr, en_eff, busy, grant, pend;
    logic [31:0]  reg_cur, merged, per_eff, window;
    logic [4:0]   pos_step;

    assign win_hit  = in_win(Addr);
    assign widx     = 3'((Addr - BASE) >> 2);
    assign bsel     = 2'(widx - REG_BUF0);
    assign cpu_wr   = win_hit && (ByteEn != 4'h0);
    assign busy     = (state_q != S_IDLE);
    assign per_eff  = (period_q == 32'd0) ? 32'd1 : period_q;
    assign pos_step = ctrl_q[CTRL_DIR] ? pos_q - 5'd1 : pos_q + 5'd1;
    assign merged   = be_merge(reg_cur, Din, ByteEn);

    always_comb begin
        reg_cur = '0;
        if (widx == REG_CTRL) begin
            reg_cur = {28'b0, ctrl_q};
        end else if (widx == REG_PERIOD) begin
            reg_cur = period_q;
        end else if (widx >= REG_BUF0 && widx <= REG_BUF3) begin
            reg_cur = buf_q[{bsel, 5'b0} +: 32];
        end else if (widx == REG_STATUS) begin
            reg_cur = {22'b0, done_q, busy, 3'b0, pos_q};
        end
    end

    always_comb begin
        Dout = '0;
        if (win_hit) begin
            Dout = reg_cur;
        end else if (in_tube(Addr)) begin
            Dout = tube_Dout;
        end
    end

    always_comb begin
        window = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            logic [4:0] idx;
            idx = pos_q + 5'(k);
            window[4*k +: 4] = buf_q[{idx, 2'b00} +: 4];
        end
    end

    // An EN clear arriving this cycle must already suppress the pending write.
    assign pend = (state_q == S_PEND) && en_eff;

    tube_port_arb u_arb (
        .Addr        (Addr),
        .ByteEn      (ByteEn),
        .Din         (Din),
        .pend_i      (pend),
        .window_i    (window),
        .tube_Addr   (tube_Addr),
        .tube_ByteEn (tube_ByteEn),
        .tube_Din    (tube_Din),
        .grant_o     (grant)
    );

    always_comb begin
        ctrl_d   = ctrl_q;
        period_d = period_q;
        buf_d    = buf_q;
        pos_d    = pos_q;
        done_d   = done_q;
        cnt_d    = cnt_q;
        state_d  = state_q;

        if (cpu_wr) begin
            if (widx == REG_CTRL) begin
                ctrl_d = merged[3:0] & CTRL_MASK;
            end else if (widx == REG_PERIOD) begin
                period_d = merged;
            end else if (widx >= REG_BUF0 && widx <= REG_BUF3) begin
                buf_d[{bsel, 5'b0} +: 32] = merged;
            end else if (widx == REG_STATUS) begin
                done_d = 1'b0;
                if (ByteEn[0] && !busy) pos_d = Din[4:0];
            end
        end
        en_eff = ctrl_d[CTRL_EN];

        unique case (state_q)
            S_IDLE: begin
                if (ctrl_q[CTRL_EN] && en_eff) begin
                    cnt_d   = '0;
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                if (!en_eff) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                    if (cnt_q + 32'd1 >= per_eff) state_d = S_PEND;
                end
            end
            S_PEND: begin
                if (!en_eff)    state_d = S_IDLE;
                else if (grant) state_d = S_STEP;
            end
            S_STEP: begin
                if (!en_eff) begin
                    state_d = S_IDLE;
                end else begin
                    pos_d = pos_step;
                    cnt_d = '0;
                    if (!ctrl_q[CTRL_REPEAT] && pos_step == 5'd0) begin
                        ctrl_d[CTRL_EN] = 1'b0;
                        done_d          = 1'b1;
                        state_d         = S_IDLE;
                    end else begin
                        state_d = S_COUNT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ctrl_q   <= '0;
            period_q <= '0;
            buf_q    <= '0;
            pos_q    <= '0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            period_q <= period_d;
            buf_q    <= buf_d;
            pos_q    <= pos_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef TUBE_SCROLL_IRQ_EN
    logic irq_q;
    always_ff @(posedge clk) begin
        if (rst) irq_q <= 1'b0;
        else     irq_q <= done_q & ctrl_q[CTRL_IRQ_EN];
    end
    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_tube_scroll_sched.sv
// Directed self-checking bench for tube_scroll_sched (irq checks when TUBE_SCROLL_IRQ_EN is defined).
module tb_tube_scroll_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Addr, Din, Dout, tube_Addr, tube_Din, tube_Dout;
    logic [3:0]  ByteEn, tube_ByteEn;
`ifdef TUBE_SCROLL_IRQ_EN
    logic        irq;
`endif

    int tests = 0;
    int fails = 0;

    localparam logic [31:0] A_CTRL   = 32'h7f60;
    localparam logic [31:0] A_PERIOD = 32'h7f64;
    localparam logic [31:0] A_BUF0   = 32'h7f68;
    localparam logic [31:0] A_BUF1   = 32'h7f6c;
    localparam logic [31:0] A_BUF3   = 32'h7f74;
    localparam logic [31:0] A_STATUS = 32'h7f78;

    tube_scroll_sched dut (
        .clk         (clk),
        .rst         (rst),
        .Addr        (Addr),
        .ByteEn      (ByteEn),
        .Din         (Din),
        .Dout        (Dout),
        .tube_Addr   (tube_Addr),
        .tube_ByteEn (tube_ByteEn),
        .tube_Din    (tube_Din),
        .tube_Dout   (tube_Dout)
`ifdef TUBE_SCROLL_IRQ_EN
        ,
        .irq         (irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
        Addr = a; ByteEn = 4'hF; Din = d;
        tick();
        Addr = '0; ByteEn = '0; Din = '0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        Addr = a; ByteEn = '0;
        #1;
        chk(tag, Dout, exp);
        Addr = '0;
    endtask

    // Waits (bus idle) for a scroller write; cyc = ticks taken, -1 on timeout.
    task automatic wait_wr(input int maxc, output int cyc, output logic [31:0] d);
        bit found = 0;
        cyc = -1;
        d   = 'x;
        for (int i = 1; i <= maxc && !found; i++) begin
            tick();
            if (tube_ByteEn == 4'hF && tube_Addr == 32'h7f50) begin
                found = 1;
                cyc   = i;
                d     = tube_Din;
            end
        end
    endtask

    initial begin
        int          cyc;
        int          nwr;
        logic [31:0] d, last_d;

        rst = 1'b1; Addr = '0; ByteEn = '0; Din = '0; tube_Dout = 32'h1234_5678;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        rd("rst_status", A_STATUS, 32'h0);
        rd("rst_ctrl", A_CTRL, 32'h0);
        chk("rst_tube_be", {28'b0, tube_ByteEn}, 32'h0);
`ifdef TUBE_SCROLL_IRQ_EN
        chk("rst_irq", {31'b0, irq}, 32'h0);
`endif

        // Left scroll, PERIOD=4
        cpu_write(A_BUF0, 32'h7654_3210);
        cpu_write(A_BUF1, 32'hFEDC_BA98);
        cpu_write(A_PERIOD, 32'd4);
        rd("period_rb", A_PERIOD, 32'd4);
        cpu_write(A_CTRL, 32'h1);
        wait_wr(20, cyc, d);
        chk("l_lat1", cyc, 32'd5);
        chk("l_dat1", d, 32'h7654_3210);
        wait_wr(20, cyc, d);
        chk("l_lat2", cyc, 32'd6);
        chk("l_dat2", d, 32'h8765_4321);
        wait_wr(20, cyc, d);
        chk("l_lat3", cyc, 32'd6);
        chk("l_dat3", d, 32'h9876_5432);
        rd("l_status_busy", A_STATUS, 32'h0000_0102);
        cpu_write(A_CTRL, 32'h0);
        rd("l_status_stop", A_STATUS, 32'h0000_0002);

        // Right scroll
        cpu_write(A_STATUS, 32'h0);
        cpu_write(A_BUF3, 32'hF000_0000);
        cpu_write(A_CTRL, 32'h3);
        wait_wr(20, cyc, d);
        chk("r_lat1", cyc, 32'd5);
        chk("r_dat1", d, 32'h7654_3210);
        wait_wr(20, cyc, d);
        chk("r_lat2", cyc, 32'd6);
        chk("r_dat2", d, 32'h6543_210F);
        cpu_write(A_CTRL, 32'h0);
        rd("r_status_stop", A_STATUS, 32'h0000_001F);

        // CPU contention delays the scroller write by one cycle
        cpu_write(A_STATUS, 32'h0);
        cpu_write(A_CTRL, 32'h1);
        wait_wr(20, cyc, d);
        chk("c_dat1", d, 32'h7654_3210);
        for (int i = 0; i < 6; i++) tick();
        Addr = 32'h7f54; ByteEn = 4'hF; Din = 32'hA5A5_A5A5;
        #1;
        chk("c_cpu_addr", tube_Addr, 32'h7f54);
        chk("c_cpu_din", tube_Din, 32'hA5A5_A5A5);
        chk("c_cpu_be", {28'b0, tube_ByteEn}, 32'hF);
        tick();
        Addr = '0; ByteEn = '0; Din = '0;
        #1;
        chk("c_late_addr", tube_Addr, 32'h7f50);
        chk("c_late_din", tube_Din, 32'h8765_4321);
        wait_wr(20, cyc, d);
        chk("c_lat3", cyc, 32'd6);
        chk("c_dat3", d, 32'h9876_5432);

        // Clear EN while PEND under CPU contention
        for (int i = 0; i < 6; i++) tick();
        Addr = 32'h7f50; ByteEn = 4'h0;
        #1;
        chk("a_rd_be", {28'b0, tube_ByteEn}, 32'h0);
        chk("a_rd_addr", tube_Addr, 32'h7f50);
        chk("a_rd_dout", Dout, 32'h1234_5678);
        tick();
        Addr = A_CTRL; ByteEn = 4'hF; Din = 32'h0;
        #1;
        chk("a_clr_be", {28'b0, tube_ByteEn}, 32'h0);
        tick();
        Addr = '0; ByteEn = '0; Din = '0;
        rd("a_status", A_STATUS, 32'h0000_0003);
        rd("unmapped", 32'h0000_1000, 32'h0);

        // One-shot, PERIOD=0
        cpu_write(A_PERIOD, 32'h0);
        cpu_write(A_STATUS, 32'h0);
        cpu_write(A_CTRL, 32'h9);
`ifdef TUBE_SCROLL_IRQ_EN
        chk("o_irq_low", {31'b0, irq}, 32'h0);
`endif
        nwr = 0;
        last_d = '0;
        for (int i = 0; i < 110; i++) begin
            tick();
            if (tube_ByteEn == 4'hF && tube_Addr == 32'h7f50) begin
                nwr++;
                last_d = tube_Din;
            end
        end
        chk("o_nwrites", nwr, 32'd32);
        chk("o_last", last_d, 32'h6543_210F);
        rd("o_status_done", A_STATUS, 32'h0000_0200);
`ifdef TUBE_SCROLL_IRQ_EN
        rd("o_ctrl", A_CTRL, 32'h8);
        chk("o_irq_high", {31'b0, irq}, 32'h1);
`else
        rd("o_ctrl", A_CTRL, 32'h0);
`endif
        cpu_write(A_STATUS, 32'h0);
`ifdef TUBE_SCROLL_IRQ_EN
        chk("o_irq_lag", {31'b0, irq}, 32'h1);
        tick();
        chk("o_irq_clr", {31'b0, irq}, 32'h0);
`endif
        rd("o_status_clr", A_STATUS, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
